pio_rx_snoop: RTL

- Receive-side counterpart of the TLP-to-FIFO transmitter.
- Snoops inbound PCIe TLPs on the 64-bit AXIS RX interface of the PCIe endpoint, filters them, and writes accepted TLPs into the XGMII-TX FIFO using the shared 72-bit tagged-word format (the same format the TX side reads).
- Maintains a free-running packet counter so the XGMII side can detect queued packets.

---
 rtl/pio_rx_snoop_pkg.sv | 31 +++
 rtl/pio_rx_snoop_filter.sv | 28 ++
 rtl/pio_rx_snoop.sv | 118 +++++++++++
 3 files changed

// File: rtl/pio_rx_snoop_pkg.sv
// Shared definitions for the RX/TX snoop paths: 72-bit FIFO word layout, TLP header fields, FSM states.
// Pure declarations; no latency and no flow control live here.
package pio_rx_snoop_pkg;

   localparam int FW_START   = 64;
   localparam int FW_END     = 65;
   localparam int FW_KEEP_LO = 66;
   localparam int FW_KEEP_HI = 67;

   localparam int         FMT_DATA_BIT = 30;
   localparam logic [4:0] TYPE_MWR     = 5'b00000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DROP    = 2'd2
   } state_t;

   function automatic logic [71:0] make_word(input logic [63:0] dat, input logic [7:0] keep,
                                             input logic sop, input logic eop);
      logic [71:0] w;
      w             = '0;
      w[63:0]       = dat;
      w[FW_START]   = sop;
      w[FW_END]     = eop;
      w[FW_KEEP_LO] = keep[0];
      w[FW_KEEP_HI] = keep[4];
      return w;
   endfunction

endpackage

// File: rtl/pio_rx_snoop_filter.sv
// Accept/drop decision for a TLP from its first DW and the snoop enable.
// Purely combinational, so it adds no latency and exerts no backpressure.
module pio_rx_snoop_filter
   import pio_rx_snoop_pkg::*;
#(
   parameter logic [9:0] MAX_LEN_DW = 10'd32,
   parameter bit         MWR_ONLY   = 1'b1
) (
   input  logic [31:0] dw0,
   input  logic        rx_enable,
   output logic        accept
);

   logic [10:0] len_dw;
   logic        is_mwr;
   logic        len_ok;
   logic        unused_hdr;

   // A zero length field encodes the maximum of 1024 DW.
   assign len_dw = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
   assign len_ok = (len_dw <= {1'b0, MAX_LEN_DW});
   assign is_mwr = dw0[FMT_DATA_BIT] && (dw0[28:24] == TYPE_MWR);

   assign accept = rx_enable && len_ok && (is_mwr || !MWR_ONLY);

   assign unused_hdr = ^{dw0[31], dw0[29], dw0[23:10]};

endmodule

// File: rtl/pio_rx_snoop.sv
// Snoops AXIS RX TLPs into the XGMII-TX FIFO as tagged 72-bit words; one cycle in-to-out, tready follows
// ~almost_full (forced high while dropping). PIO_RX_SNOOP_STATS_EN builds the saturating drop counter.
module pio_rx_snoop
   import pio_rx_snoop_pkg::*;
#(
   parameter logic [9:0] MAX_LEN_DW = 10'd32,
   parameter bit         MWR_ONLY   = 1'b1
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic [63:0] m_axis_rx_tdata,
   input  logic [7:0]  m_axis_rx_tkeep,
   input  logic        m_axis_rx_tlast,
   input  logic        m_axis_rx_tvalid,
   output logic        m_axis_rx_tready,
   input  logic        rx_enable,
   output logic [71:0] din,
   output logic        wr_en,
   input  logic        almost_full,
   output logic [7:0]  tlp_pktcount,
   output logic [15:0] drop_count
);

   state_t state, state_nxt;
   logic   take, accept;
   logic   wr_nxt, sop_nxt, eop_nxt, cnt_inc, drop_evt, tready_nxt;
   logic   unused_keep;

   assign take        = m_axis_rx_tvalid && m_axis_rx_tready;
   assign unused_keep = ^{m_axis_rx_tkeep[7:5], m_axis_rx_tkeep[3:1]};

   pio_rx_snoop_filter #(
      .MAX_LEN_DW (MAX_LEN_DW),
      .MWR_ONLY   (MWR_ONLY)
   ) u_filter (
      .dw0       (m_axis_rx_tdata[31:0]),
      .rx_enable (rx_enable),
      .accept    (accept)
   );

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_nxt    = 1'b0;
      sop_nxt   = 1'b0;
      eop_nxt   = 1'b0;
      cnt_inc   = 1'b0;
      drop_evt  = 1'b0;
      if (take) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr_nxt  = 1'b1;
                  sop_nxt = 1'b1;
                  if (m_axis_rx_tlast) begin
                     eop_nxt = 1'b1;
                     cnt_inc = 1'b1;
                  end else begin
                     state_nxt = CAPTURE;
                  end
               end else begin
                  drop_evt = 1'b1;
                  if (!m_axis_rx_tlast) state_nxt = DROP;
               end
            end
            CAPTURE: begin
               wr_nxt  = 1'b1;
               eop_nxt = m_axis_rx_tlast;
               if (m_axis_rx_tlast) begin
                  cnt_inc   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            DROP: begin
               if (m_axis_rx_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
      // Dropped TLPs drain at line rate; they never reach the FIFO.
      tready_nxt = (state_nxt == DROP) ? 1'b1 : ~almost_full;
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_axis_rx_tready <= 1'b0;
         wr_en            <= 1'b0;
         din              <= 72'h0;
         tlp_pktcount     <= 8'h00;
      end else begin
         m_axis_rx_tready <= tready_nxt;
         wr_en            <= wr_nxt;
         if (wr_nxt) din <= make_word(m_axis_rx_tdata, m_axis_rx_tkeep, sop_nxt, eop_nxt);
         if (cnt_inc) tlp_pktcount <= tlp_pktcount + 8'd1;
      end
   end

`ifdef PIO_RX_SNOOP_STATS_EN
   logic [15:0] drop_q;

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst)                              drop_q <= 16'h0000;
      else if (drop_evt && drop_q != 16'hFFFF)  drop_q <= drop_q + 16'd1;
   end

   assign drop_count = drop_q;
`else
   logic unused_drop;

   assign unused_drop = drop_evt;
   assign drop_count  = 16'h0000;
`endif

endmodule
